// File: rtl/r_order_pkg.sv
// Shared types and sizing helpers for the R-channel ordering arbiter.
package r_order_pkg;

   typedef enum logic {R_IDLE, R_BURST} r_state_e;

   localparam int PERF_CNT_W = 32;

   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/r_order_id_fifo.sv
// Per-ID issue-order FIFO of slave indices; push while full is dropped unless a pop frees the slot.
module r_order_id_fifo
   import r_order_pkg::*;
#(
   parameter int SEL_W = 3,
   parameter int DEPTH = 4,
   localparam int CNT_W = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [SEL_W-1:0] din,
   output logic [SEL_W-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [SEL_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             full, do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // a same-cycle pop frees the slot, so push is accepted even when full
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push != do_pop)
            count <= do_push ? count + CNT_W'(1) : count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/r_order_arbiter_param.sv
// Round-robin R-burst arbiter that only grants a slave when it is the oldest AR target for its ID.
// Optional ordering-stall counter enabled by defining R_ORDER_PERF_EN.
module r_order_arbiter_param
   import r_order_pkg::*;
#(
   parameter int NUM_SLV = 5,
   parameter int SID_W   = 6,
   parameter int MID_W   = 2,
   parameter int DEPTH   = 4,
   localparam int NUM_ID = 2**MID_W,
   localparam int SEL_W  = sel_w(NUM_SLV)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     ar_push,
   input  logic [MID_W-1:0]         ar_id,
   input  logic [SEL_W-1:0]         ar_slv,
   output logic [NUM_ID-1:0]        ar_ready,
   input  logic [NUM_SLV-1:0]       s_rvalid,
   input  logic [NUM_SLV*SID_W-1:0] s_rid,
   input  logic [NUM_SLV-1:0]       s_rlast,
   output logic [NUM_SLV-1:0]       s_rready,
   input  logic                     m_rready,
   output logic                     m_rvalid,
   output logic [SEL_W-1:0]         r_slv_sel,
   output logic                     r_grant,
   output logic                     hold,
   output logic [PERF_CNT_W-1:0]    perf_blocked_cnt
);

   localparam int CNT_W = cnt_w(DEPTH);

   r_state_e                       state, state_nxt;
   logic [SEL_W-1:0]               sel_nxt, rr_ptr, rr_nxt, pick, cand;
   logic                           found, hs_last;
   logic [NUM_SLV-1:0][MID_W-1:0]  key;
   logic [NUM_SLV-1:0]             elig;
   logic [NUM_ID-1:0]              push, pop, empty;
   logic [NUM_ID-1:0][SEL_W-1:0]   head;
   logic [NUM_ID-1:0][CNT_W-1:0]   count;
   logic                           rid_unused;

   // only the low MID_W bits of each RID form the ordering key
   assign rid_unused = ^s_rid;

   for (genvar s = 0; s < NUM_SLV; s++) begin : g_slv
      assign key[s]  = s_rid[s*SID_W +: MID_W];
      assign elig[s] = s_rvalid[s] & ~empty[key[s]] & (head[key[s]] == SEL_W'(s));
   end

   for (genvar k = 0; k < NUM_ID; k++) begin : g_id
      assign push[k]     = ar_push & (ar_id == MID_W'(k));
      assign pop[k]      = hs_last & (key[r_slv_sel] == MID_W'(k));
      assign ar_ready[k] = (count[k] != CNT_W'(DEPTH));

      r_order_id_fifo #(.SEL_W(SEL_W), .DEPTH(DEPTH)) u_fifo (
         .clk     (clk),
         .reset_n (reset_n),
         .push    (push[k]),
         .pop     (pop[k]),
         .din     (ar_slv),
         .head    (head[k]),
         .count   (count[k]),
         .empty   (empty[k])
      );
   end

   // first eligible slave after the last winner, wrapping modulo NUM_SLV
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int i = 1; i <= NUM_SLV; i++) begin
         cand = SEL_W'((int'(rr_ptr) + i) % NUM_SLV);
         if (!found && elig[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= R_IDLE;
         r_slv_sel <= '0;
         rr_ptr    <= SEL_W'(NUM_SLV - 1);
         hold      <= 1'b0;
      end else begin
         state     <= state_nxt;
         r_slv_sel <= sel_nxt;
         rr_ptr    <= rr_nxt;
         hold      <= (state == R_IDLE) & ~|elig;
      end
   end

   always_comb begin
      state_nxt = state;
      sel_nxt   = r_slv_sel;
      rr_nxt    = rr_ptr;
      r_grant   = 1'b0;
      m_rvalid  = 1'b0;
      s_rready  = '0;
      hs_last   = 1'b0;
      unique case (state)
         R_IDLE: begin
            if (found) begin
               sel_nxt   = pick;
               state_nxt = R_BURST;
            end
         end
         R_BURST: begin
            r_grant  = 1'b1;
            m_rvalid = s_rvalid[r_slv_sel];
            if (m_rready) s_rready[r_slv_sel] = 1'b1;
            hs_last  = s_rvalid[r_slv_sel] & m_rready & s_rlast[r_slv_sel];
            if (hs_last) begin
               state_nxt = R_IDLE;
               rr_nxt    = r_slv_sel;
            end
         end
         default: state_nxt = R_IDLE;
      endcase
   end

`ifdef R_ORDER_PERF_EN
   logic [PERF_CNT_W-1:0] blocked_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         blocked_cnt <= '0;
      else if (|(s_rvalid & ~elig) && (blocked_cnt != '1))
         blocked_cnt <= blocked_cnt + PERF_CNT_W'(1);
   end

   assign perf_blocked_cnt = blocked_cnt;
`else
   assign perf_blocked_cnt = '0;
`endif

endmodule

// File: tb/tb_r_order_arbiter_param.sv
// Directed bench for r_order_arbiter_param: per-cycle vector table plus hand-written corner sequences.
module tb_r_order_arbiter_param;

   logic        clk, reset_n;
   logic        ar_push;
   logic [1:0]  ar_id;
   logic [2:0]  ar_slv;
   logic [3:0]  ar_ready;
   logic [4:0]  s_rvalid, s_rlast, s_rready;
   logic [29:0] s_rid;
   logic        m_rready, m_rvalid, r_grant, hold;
   logic [2:0]  r_slv_sel;
   logic [31:0] perf_blocked_cnt;
   logic [1:0]  key [5];

   int checks, errors;
   int n;
   logic       hs;
   logic [2:0] sel_l;
   logic [2:0] order [3];

   r_order_arbiter_param dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .ar_push          (ar_push),
      .ar_id            (ar_id),
      .ar_slv           (ar_slv),
      .ar_ready         (ar_ready),
      .s_rvalid         (s_rvalid),
      .s_rid            (s_rid),
      .s_rlast          (s_rlast),
      .s_rready         (s_rready),
      .m_rready         (m_rready),
      .m_rvalid         (m_rvalid),
      .r_slv_sel        (r_slv_sel),
      .r_grant          (r_grant),
      .hold             (hold),
      .perf_blocked_cnt (perf_blocked_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // upper RID bits carry junk; only the low key bits must matter
   always_comb begin
      s_rid = '0;
      for (int s = 0; s < 5; s++) s_rid[s*6 +: 6] = {4'b1010, key[s]};
   end

   typedef struct {
      logic       push;
      logic [1:0] id;
      logic [2:0] slv;
      logic [4:0] rv;
      logic [4:0] rl;
      logic [1:0] k;
      logic       mrdy;
      logic       e_mrv;
      logic [4:0] e_srr;
      logic [2:0] e_sel;
      logic       e_gnt;
      logic       e_hold;
      logic [3:0] e_arr;
   } vec_t;

   vec_t vec [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clk_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0; errors = 0;
      reset_n = 1'b0; ar_push = 1'b0; ar_id = '0; ar_slv = '0;
      s_rvalid = '0; s_rlast = '0; m_rready = 1'b0;
      for (int s = 0; s < 5; s++) key[s] = 2'd0;

      // single 4-beat burst from slave 3, key 1, then a stray RVALID with nothing outstanding
      vec[0] = '{1'b1, 2'd1, 3'd3, 5'b00000, 5'b00000, 2'd1, 1'b1, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 4'hF};
      vec[1] = '{1'b0, 2'd0, 3'd0, 5'b01000, 5'b00000, 2'd1, 1'b1, 1'b0, 5'b00000, 3'd0, 1'b0, 1'b1, 4'hF};
      vec[2] = '{1'b0, 2'd0, 3'd0, 5'b01000, 5'b00000, 2'd1, 1'b1, 1'b1, 5'b01000, 3'd3, 1'b1, 1'b0, 4'hF};
      vec[3] = '{1'b0, 2'd0, 3'd0, 5'b01000, 5'b00000, 2'd1, 1'b1, 1'b1, 5'b01000, 3'd3, 1'b1, 1'b0, 4'hF};
      vec[4] = '{1'b0, 2'd0, 3'd0, 5'b01000, 5'b00000, 2'd1, 1'b1, 1'b1, 5'b01000, 3'd3, 1'b1, 1'b0, 4'hF};
      vec[5] = '{1'b0, 2'd0, 3'd0, 5'b01000, 5'b01000, 2'd1, 1'b1, 1'b1, 5'b01000, 3'd3, 1'b1, 1'b0, 4'hF};
      vec[6] = '{1'b0, 2'd0, 3'd0, 5'b00000, 5'b00000, 2'd1, 1'b1, 1'b0, 5'b00000, 3'd3, 1'b0, 1'b0, 4'hF};
      vec[7] = '{1'b0, 2'd0, 3'd0, 5'b01000, 5'b00000, 2'd1, 1'b1, 1'b0, 5'b00000, 3'd3, 1'b0, 1'b1, 4'hF};
      vec[8] = '{1'b0, 2'd0, 3'd0, 5'b01000, 5'b00000, 2'd1, 1'b1, 1'b0, 5'b00000, 3'd3, 1'b0, 1'b1, 4'hF};

      repeat (2) @(posedge clk);
      #1;
      chk("rst.grant", r_grant, 0);
      chk("rst.m_rvalid", m_rvalid, 0);
      chk("rst.s_rready", s_rready, 0);
      chk("rst.sel", r_slv_sel, 0);
      chk("rst.hold", hold, 0);
      chk("rst.ar_ready", ar_ready, 4'hF);
      reset_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         ar_push = vec[i].push; ar_id = vec[i].id; ar_slv = vec[i].slv;
         s_rvalid = vec[i].rv; s_rlast = vec[i].rl; m_rready = vec[i].mrdy;
         for (int s = 0; s < 5; s++) key[s] = vec[i].k;
         #2;
         chk($sformatf("v%0d.m_rvalid", i), m_rvalid, vec[i].e_mrv);
         chk($sformatf("v%0d.s_rready", i), s_rready, vec[i].e_srr);
         chk($sformatf("v%0d.sel", i), r_slv_sel, vec[i].e_sel);
         chk($sformatf("v%0d.grant", i), r_grant, vec[i].e_gnt);
         chk($sformatf("v%0d.hold", i), hold, vec[i].e_hold);
         chk($sformatf("v%0d.ar_ready", i), ar_ready, vec[i].e_arr);
         clk_step();
      end

      // same-ID ordering: slave 4 answers first but slave 0 holds the older AR on id 2
      ar_push = 1'b1; ar_id = 2'd2; ar_slv = 3'd0; s_rvalid = '0; s_rlast = '0; clk_step();
      ar_slv = 3'd4; clk_step();
      ar_push = 1'b0; key[4] = 2'd2; s_rvalid = 5'b10000;
      #2; chk("ord.blk0", r_grant, 0); clk_step();
      #2; chk("ord.blk1", r_grant, 0); chk("ord.hold", hold, 1); clk_step();
      key[0] = 2'd2; s_rvalid = 5'b10001;
      #2; chk("ord.blk2", r_grant, 0); clk_step();
      #2; chk("ord.sel0", r_slv_sel, 0); chk("ord.gnt0", r_grant, 1); chk("ord.srr0", s_rready, 5'b00001); clk_step();
      s_rlast = 5'b00001;
      #2; chk("ord.srr0_last", s_rready, 5'b00001); clk_step();
      s_rvalid = 5'b10000; s_rlast = 5'b10000;
      #2; chk("ord.arb4", r_grant, 0); clk_step();
      #2; chk("ord.sel4", r_slv_sel, 4); chk("ord.srr4", s_rready, 5'b10000); clk_step();
      s_rvalid = '0; s_rlast = '0;
      #2; chk("ord.done", r_grant, 0);
`ifdef R_ORDER_PERF_EN
      chk("ord.perf_ge2", perf_blocked_cnt >= 32'd2, 1);
`else
      chk("ord.perf_off", perf_blocked_cnt, 0);
`endif
      clk_step();

      // round robin over slaves 0,1,2 twice
      for (int r = 0; r < 2; r++) begin
         for (int s = 0; s < 3; s++) begin
            ar_push = 1'b1; ar_id = 2'(s); ar_slv = 3'(s); clk_step();
         end
         ar_push = 1'b0;
         key[0] = 2'd0; key[1] = 2'd1; key[2] = 2'd2;
         s_rvalid = 5'b00111; s_rlast = 5'b00111; m_rready = 1'b1;
         n = 0;
         for (int k = 0; k < 3; k++) order[k] = 3'd7;
         for (int c = 0; c < 12 && n < 3; c++) begin
            #2;
            hs = r_grant && (s_rready != '0);
            sel_l = r_slv_sel;
            if (hs) begin order[n] = r_slv_sel; n++; end
            clk_step();
            if (hs) s_rvalid[sel_l] = 1'b0;
         end
         for (int k = 0; k < 3; k++) chk($sformatf("rr%0d.order%0d", r, k), order[k], k);
      end
      s_rvalid = '0; s_rlast = '0;

      // backpressure on id 0
      ar_id = 2'd0; ar_slv = 3'd1;
      for (int i = 0; i < 4; i++) begin ar_push = 1'b1; clk_step(); end
      ar_push = 1'b0; key[1] = 2'd0; s_rvalid = 5'b00010; s_rlast = 5'b00010;
      #2; chk("bp.full", ar_ready, 4'b1110); clk_step();
      #2; chk("bp.full_burst", ar_ready, 4'b1110); chk("bp.sel1", r_slv_sel, 1); clk_step();
      s_rvalid = '0; ar_push = 1'b1;
      #2; chk("bp.freed", ar_ready, 4'hF); clk_step();
      ar_push = 1'b0; s_rvalid = 5'b00010;
      #2; chk("bp.refull", ar_ready, 4'b1110); clk_step();
      ar_push = 1'b1;
      #2; chk("bp.pp_grant", r_grant, 1); clk_step();
      ar_push = 1'b0; s_rvalid = '0;
      #2; chk("bp.pushpop", ar_ready, 4'b1110); clk_step();

      // mid-burst stall on slave 3 while slave 1 is also eligible
      ar_push = 1'b1; ar_id = 2'd3; ar_slv = 3'd3; clk_step();
      ar_push = 1'b0; key[3] = 2'd3; s_rvalid = 5'b01010; s_rlast = '0; m_rready = 1'b1;
      #2; chk("st.arb", r_grant, 0); clk_step();
      #2; chk("st.sel", r_slv_sel, 3); chk("st.srr_b1", s_rready, 5'b01000); clk_step();
      m_rready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk($sformatf("st.srr_stall%0d", i), s_rready, 0);
         chk($sformatf("st.sel_stall%0d", i), r_slv_sel, 3);
         chk($sformatf("st.mrv_stall%0d", i), m_rvalid, 1);
         clk_step();
      end
      m_rready = 1'b1;
      #2; chk("st.srr_b2", s_rready, 5'b01000); clk_step();
      s_rlast = 5'b01000;
      #2; chk("st.srr_b3", s_rready, 5'b01000); clk_step();
      s_rvalid = 5'b00010; s_rlast = '0;
      #2; chk("st.idle", r_grant, 0); clk_step();
      #2; chk("st.next_sel", r_slv_sel, 1); chk("st.next_srr", s_rready, 5'b00010); clk_step();

      // reset during beat 2 of slave 1's burst
      #2; chk("rm.pre_arr", ar_ready, 4'b1110); chk("rm.pre_gnt", r_grant, 1);
      reset_n = 1'b0;
      #1;
      chk("rm.grant", r_grant, 0);
      chk("rm.m_rvalid", m_rvalid, 0);
      chk("rm.s_rready", s_rready, 0);
      chk("rm.sel", r_slv_sel, 0);
      chk("rm.hold", hold, 0);
      chk("rm.ar_ready", ar_ready, 4'hF);
      s_rvalid = '0; clk_step();
      reset_n = 1'b1;
      ar_push = 1'b1; ar_id = 2'd0; ar_slv = 3'd0; clk_step();
      ar_id = 2'd1; ar_slv = 3'd4; clk_step();
      ar_push = 1'b0; key[0] = 2'd0; key[4] = 2'd1; s_rvalid = 5'b10001; s_rlast = 5'b10001;
      clk_step();
      #2; chk("rm.prio_sel", r_slv_sel, 0); chk("rm.prio_gnt", r_grant, 1);
      clk_step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/r_order_arbiter_param.md
Name: r_order_arbiter_param

Overview:
- Parametrised read-response ordering arbiter for the AXI node R channel.
- Forwards R bursts from NUM_SLV slave ports to one master port with round-robin fairness.
- Enforces AXI same-ID ordering: a response burst for an ID is forwarded only if its slave is the oldest outstanding AR target for that ID.
- Generalises the fixed 5-slave / 4-ID controller with per-ID issue-order tracking, burst locking and AR-side backpressure.

Parameters:
- NUM_SLV, 5, number of slave ports (2..16)
- SID_W, 6, slave-side RID width
- MID_W, 2, ordering-key width; key = RID[MID_W-1:0]; NUM_ID = 2**MID_W
- DEPTH, 4, outstanding ARs tracked per ID (power of 2, >= 2)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- ar_push  in  1  AR handshake completed this cycle (ARVALID & ARREADY)
- ar_id  in  MID_W  ordering key of the pushed AR
- ar_slv  in  SEL_W  target slave index of the pushed AR
- ar_ready  out  NUM_ID  per-ID "not full"; the AR path must not issue ID k while bit k is 0
- s_rvalid  in  NUM_SLV  per-slave RVALID
- s_rid  in  NUM_SLV*SID_W  per-slave RID, slave s at bits [s*SID_W +: SID_W]
- s_rlast  in  NUM_SLV  per-slave RLAST
- s_rready  out  NUM_SLV  per-slave RREADY, one-hot or zero
- m_rready  in  1  master RREADY
- m_rvalid  out  1  master RVALID
- r_slv_sel  out  SEL_W  slave index driving the master R mux; SEL_W = max(1,$clog2(NUM_SLV))
- r_grant  out  1  burst in progress
- hold  out  1  registered: no eligible response in the previous cycle
- perf_blocked_cnt  out  32  ordering-stall counter (feature only)

Behaviour:
- Reset values: state IDLE; all per-ID FIFOs empty; rr_ptr = NUM_SLV-1, so slave 0 has first priority; r_slv_sel = 0; r_grant = 0; hold = 0; m_rvalid = 0; s_rready = 0; ar_ready = all ones.
- Per-ID FIFO k holds slave indices in AR issue order.
  - Push on ar_push to FIFO ar_id.
  - Pop on the final beat handshake of a granted burst with key k.
  - Push and pop on the same FIFO in the same cycle: both take effect, count unchanged, legal even when full.
  - ar_ready[k] = count_k != DEPTH.
  - ar_push while full is a protocol violation: the push is dropped.
- Eligibility: elig[s] = s_rvalid[s] & FIFO[key(s)] non-empty & head(FIFO[key(s)]) == s.
  - s_rvalid from a slave with no matching outstanding entry is never eligible and waits indefinitely.
- FSM IDLE:
  - If elig != 0, pick the first set bit searching from rr_ptr+1, wrapping modulo NUM_SLV.
  - Register it into r_slv_sel and go to BURST.
  - Arbitration latency is 1 cycle; no data is forwarded while in IDLE.
- FSM BURST:
  - r_grant = 1.
  - m_rvalid = s_rvalid[sel].
  - s_rready = onehot(sel) & m_rready.
  - A beat handshake occurs when s_rvalid[sel] & m_rready.
  - On a handshake with s_rlast[sel] = 1: pop FIFO[key(sel)], set rr_ptr = sel, return to IDLE.
  - Selection never changes mid-burst.
- hold is registered each cycle: hold <= (state==IDLE) & (elig==0).
- A newly pushed AR affects elig from the next cycle; it is not a same-cycle bypass.
- Reset asserted mid-burst: all state returns to reset values immediately; any partially forwarded burst is abandoned.

Optional Feature:
- Macro: R_ORDER_PERF_EN.
- Defined:
  - perf_blocked_cnt increments each cycle in which some s_rvalid[s] = 1 and elig[s] = 0, i.e. blocked by ordering.
  - The counter saturates at 32'hFFFF_FFFF.
  - Reset value is 0.
- Undefined: perf_blocked_cnt is tied to 0 and no counter logic is instantiated.

Decomposition:
- Package r_order_pkg holds:
  - the state enum (R_IDLE, R_BURST)
  - localparam helper functions for SEL_W and the count width $clog2(DEPTH)+1
  - the PERF_CNT_W = 32 constant
- Sub-module r_order_id_fifo holds one per-ID FIFO of SEL_W-bit entries, with push/pop/head/count/full/empty. It is instantiated NUM_ID times via generate.

Test Plan:
- Single burst: push ar_id=1, ar_slv=3; slave 3 returns a 4-beat burst with RID key 1 while m_rready=1 -> r_slv_sel=3 one cycle after RVALID; 4 beats forwarded; FIFO 1 empty after RLAST; hold=1 the following cycle.
- Ordering: push id 2 to slave 0, then id 2 to slave 4; slave 4 responds first, slave 0 two cycles later -> slave 4 is not granted until slave 0's burst completes; with R_ORDER_PERF_EN, perf_blocked_cnt >= 2.
- Round robin: one outstanding AR on each of slaves 0,1,2 with distinct ids, all RVALID together -> grant order 0,1,2; repeat immediately -> order 0,1,2 again (rr_ptr=2 after the first round).
- Backpressure: push DEPTH=4 ARs on id 0 -> ar_ready[0]=0, other bits remain 1; completing one burst -> ar_ready[0]=1 the next cycle; push and pop in the same cycle while full -> count stays 4.
- Stall mid-burst: m_rready low for 3 cycles in the middle of a burst -> s_rready[sel]=0 during those cycles, r_slv_sel stable, no other slave is granted.
- Reset mid-burst: assert reset_n=0 during beat 2 -> outputs return to reset values; ar_ready all ones; rr_ptr restores slave 0 priority.
